cdb_arbiter: RTL and testbench

//  Shares the single common-data-bus writeback port (ROB commit-ready write + RS/SLB wakeup)

---
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer-side requests (EX, SLB), backpressure, and the registered CDB broadcast.
// master = the producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if #(
  parameter int unsigned NICK_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              iEX_en;
  logic [NICK_W-1:0] iEX_nick;
  logic [DATA_W-1:0] iEX_dt;
  logic              iEX_ac;
  logic [ADDR_W-1:0] iEX_j_pc;
  logic              oEX_stall;

  logic              iSLB_en;
  logic [NICK_W-1:0] iSLB_nick;
  logic [DATA_W-1:0] iSLB_dt;
  logic              oSLB_stall;

  logic              oCDB_en;
  logic              oCDB_src;
  logic [NICK_W-1:0] oCDB_nick;
  logic [DATA_W-1:0] oCDB_dt;
  logic              oCDB_ac;
  logic [ADDR_W-1:0] oCDB_j_pc;

  modport master (
    output iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
    output iSLB_en, iSLB_nick, iSLB_dt,
    input  oEX_stall, oSLB_stall,
    input  oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc
  );

  modport slave (
    input  iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc,
    input  iSLB_en, iSLB_nick, iSLB_dt,
    output oEX_stall, oSLB_stall,
    output oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the EX unit and the store/load buffer.
// Each producer has a skid FIFO; a round-robin scheduler broadcasts one head per cycle
// through registered oCDB_* outputs.
// Optional feature macro: CDB_BYPASS_EN -- an empty FIFO's request competes in the same cycle
// and, if it wins, skips the FIFO (latency 1 instead of 2).
module cdb_arbiter #(
  parameter int unsigned NICK_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          iclr,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {
    SrcEx  = 1'b0,
    SrcSlb = 1'b1
  } src_e;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
    logic              ac;
    logic [ADDR_W-1:0] j_pc;
  } ex_entry_t;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } slb_entry_t;

  // FIFO storage and pointers; pointers wrap naturally since the depth is a power of 2
  ex_entry_t       ex_mem [FIFO_DEPTH];
  logic [PtrW-1:0] ex_wr_q, ex_rd_q;
  logic [CntW-1:0] ex_cnt_q, ex_cnt_d;

  slb_entry_t      slb_mem [FIFO_DEPTH];
  logic [PtrW-1:0] slb_wr_q, slb_rd_q;
  logic [CntW-1:0] slb_cnt_q, slb_cnt_d;

  src_e last_grant_q;

  logic              cdb_en_q;
  src_e              cdb_src_q;
  logic [NICK_W-1:0] cdb_nick_q;
  logic [DATA_W-1:0] cdb_dt_q;
  logic              cdb_ac_q;
  logic [ADDR_W-1:0] cdb_j_pc_q;

  logic       ex_full, slb_full;
  logic       ex_byp, slb_byp;
  logic       ex_cand, slb_cand;
  logic       grant_ex, grant_slb;
  logic       ex_push, ex_pop, slb_push, slb_pop;
  ex_entry_t  ex_in, ex_head;
  slb_entry_t slb_in, slb_head;

  assign ex_in  = {bus.iEX_nick, bus.iEX_dt, bus.iEX_ac, bus.iEX_j_pc};
  assign slb_in = {bus.iSLB_nick, bus.iSLB_dt};

  // Stall looks only at the registered count, so a same-cycle pop never releases it early
  assign ex_full  = (ex_cnt_q == CntW'(FIFO_DEPTH));
  assign slb_full = (slb_cnt_q == CntW'(FIFO_DEPTH));

  // Round-robin scheduling over the FIFO heads (plus same-cycle requests when bypass is built)
  always_comb begin
    ex_byp  = 1'b0;
    slb_byp = 1'b0;
`ifdef CDB_BYPASS_EN
    ex_byp  = (ex_cnt_q == '0) && bus.iEX_en;
    slb_byp = (slb_cnt_q == '0) && bus.iSLB_en;
`endif
    ex_cand  = (ex_cnt_q != '0) || ex_byp;
    slb_cand = (slb_cnt_q != '0) || slb_byp;

    // With both eligible, the side that did not win last time goes first
    grant_ex  = ex_cand && (!slb_cand || (last_grant_q == SrcSlb));
    grant_slb = slb_cand && !grant_ex;

    ex_head  = ex_byp ? ex_in : ex_mem[ex_rd_q];
    slb_head = slb_byp ? slb_in : slb_mem[slb_rd_q];

    // A winning bypass request goes straight to the bus and never occupies the FIFO
    ex_pop   = grant_ex && !ex_byp;
    slb_pop  = grant_slb && !slb_byp;
    ex_push  = bus.iEX_en && !ex_full && !(grant_ex && ex_byp);
    slb_push = bus.iSLB_en && !slb_full && !(grant_slb && slb_byp);

    ex_cnt_d  = ex_cnt_q + CntW'(ex_push) - CntW'(ex_pop);
    slb_cnt_d = slb_cnt_q + CntW'(slb_push) - CntW'(slb_pop);
  end

  // FIFO payload writes; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (!rst && rdy && !iclr) begin
      if (ex_push) ex_mem[ex_wr_q] <= ex_in;
      if (slb_push) slb_mem[slb_wr_q] <= slb_in;
    end
  end

  // FIFO pointers and occupancy; flush empties both queues
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr_q   <= '0;
      ex_rd_q   <= '0;
      ex_cnt_q  <= '0;
      slb_wr_q  <= '0;
      slb_rd_q  <= '0;
      slb_cnt_q <= '0;
    end else if (rdy) begin
      if (iclr) begin
        ex_wr_q   <= '0;
        ex_rd_q   <= '0;
        ex_cnt_q  <= '0;
        slb_wr_q  <= '0;
        slb_rd_q  <= '0;
        slb_cnt_q <= '0;
      end else begin
        if (ex_push) ex_wr_q <= ex_wr_q + 1'b1;
        if (ex_pop) ex_rd_q <= ex_rd_q + 1'b1;
        if (slb_push) slb_wr_q <= slb_wr_q + 1'b1;
        if (slb_pop) slb_rd_q <= slb_rd_q + 1'b1;
        ex_cnt_q  <= ex_cnt_d;
        slb_cnt_q <= slb_cnt_d;
      end
    end
  end

  // Registered broadcast; data regs hold their last value while no grant is made
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_en_q     <= 1'b0;
      cdb_src_q    <= SrcEx;
      cdb_nick_q   <= '0;
      cdb_dt_q     <= '0;
      cdb_ac_q     <= 1'b0;
      cdb_j_pc_q   <= '0;
      last_grant_q <= SrcSlb;
    end else if (rdy) begin
      if (iclr) begin
        cdb_en_q     <= 1'b0;
        last_grant_q <= SrcSlb;
      end else if (grant_ex) begin
        cdb_en_q     <= 1'b1;
        cdb_src_q    <= SrcEx;
        cdb_nick_q   <= ex_head.nick;
        cdb_dt_q     <= ex_head.dt;
        cdb_ac_q     <= ex_head.ac;
        cdb_j_pc_q   <= ex_head.j_pc;
        last_grant_q <= SrcEx;
      end else if (grant_slb) begin
        cdb_en_q     <= 1'b1;
        cdb_src_q    <= SrcSlb;
        cdb_nick_q   <= slb_head.nick;
        cdb_dt_q     <= slb_head.dt;
        cdb_ac_q     <= 1'b0;
        cdb_j_pc_q   <= '0;
        last_grant_q <= SrcSlb;
      end else begin
        cdb_en_q <= 1'b0;
      end
    end
  end

  // Report producers that ignore backpressure; such requests are simply not pushed
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      assert (!(bus.iEX_en && ex_full))
        else $error("cdb_arbiter: iEX_en while oEX_stall, request dropped");
      assert (!(bus.iSLB_en && slb_full))
        else $error("cdb_arbiter: iSLB_en while oSLB_stall, request dropped");
    end
  end

  assign bus.oEX_stall  = ex_full;
  assign bus.oSLB_stall = slb_full;
  assign bus.oCDB_en    = cdb_en_q;
  assign bus.oCDB_src   = cdb_src_q;
  assign bus.oCDB_nick  = cdb_nick_q;
  assign bus.oCDB_dt    = cdb_dt_q;
  assign bus.oCDB_ac    = cdb_ac_q;
  assign bus.oCDB_j_pc  = cdb_j_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic, checked against a queue-based
// reference model of the two producers and the round-robin bus.
module tb_cdb_arbiter;
  localparam int unsigned NickW = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 32;
  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [NickW-1:0] nick;
    logic [DataW-1:0] dt;
    logic             ac;
    logic [AddrW-1:0] j_pc;
  } ex_ent_t;

  typedef struct packed {
    logic [NickW-1:0] nick;
    logic [DataW-1:0] dt;
  } slb_ent_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic iclr;

  cdb_arbiter_if #(.NICK_W(NickW), .DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  cdb_arbiter #(
    .NICK_W    (NickW),
    .DATA_W    (DataW),
    .ADDR_W    (AddrW),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .iclr(iclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: one queue per producer and the visible bus state
  ex_ent_t          mq_ex[$];
  slb_ent_t         mq_slb[$];
  bit               m_last;  // 1 = SLB won last
  bit               m_en;
  bit               m_src;
  logic [NickW-1:0] m_nick;
  logic [DataW-1:0] m_dt;
  bit               m_ac;
  logic [AddrW-1:0] m_jpc;

  ex_ent_t  ex_none  = '0;
  slb_ent_t slb_none = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_ent_t mk_ex(input int nick, input int dt, input bit ac, input int jpc);
    ex_ent_t e;
    e.nick = NickW'(nick);
    e.dt   = DataW'(dt);
    e.ac   = ac;
    e.j_pc = AddrW'(jpc);
    return e;
  endfunction

  function automatic slb_ent_t mk_slb(input int nick, input int dt);
    slb_ent_t e;
    e.nick = NickW'(nick);
    e.dt   = DataW'(dt);
    return e;
  endfunction

  function automatic ex_ent_t rand_ex();
    return mk_ex($urandom_range(1, 31), $urandom, 1'($urandom_range(0, 1)), $urandom);
  endfunction

  function automatic slb_ent_t rand_slb();
    return mk_slb($urandom_range(1, 31), $urandom);
  endfunction

  // Apply one clock edge to the model
  task automatic model_edge(input bit r, input bit rd, input bit clr,
                            input bit xe, input ex_ent_t xv, input bit se, input slb_ent_t sv);
    bit      x_full, s_full, x_avail, s_avail, x_byp, s_byp;
    int      win;
    ex_ent_t xh;
    slb_ent_t sh;
    if (r) begin
      mq_ex.delete();
      mq_slb.delete();
      m_last = 1'b1;
      m_en   = 1'b0;
      m_src  = 1'b0;
      m_nick = '0;
      m_dt   = '0;
      m_ac   = 1'b0;
      m_jpc  = '0;
    end else if (!rd) begin
      // frozen
    end else if (clr) begin
      mq_ex.delete();
      mq_slb.delete();
      m_en   = 1'b0;
      m_last = 1'b1;
    end else begin
      x_full  = (mq_ex.size() == Depth);
      s_full  = (mq_slb.size() == Depth);
      x_avail = (mq_ex.size() != 0);
      s_avail = (mq_slb.size() != 0);
      x_byp   = 1'b0;
      s_byp   = 1'b0;
`ifdef CDB_BYPASS_EN
      if (!x_avail && xe) begin x_avail = 1'b1; x_byp = 1'b1; end
      if (!s_avail && se) begin s_avail = 1'b1; s_byp = 1'b1; end
`endif
      win = -1;
      if (x_avail && s_avail) win = m_last ? 0 : 1;
      else if (x_avail) win = 0;
      else if (s_avail) win = 1;

      if (win == 0) begin
        xh     = x_byp ? xv : mq_ex.pop_front();
        m_en   = 1'b1;
        m_src  = 1'b0;
        m_nick = xh.nick;
        m_dt   = xh.dt;
        m_ac   = xh.ac;
        m_jpc  = xh.j_pc;
        m_last = 1'b0;
      end else if (win == 1) begin
        sh     = s_byp ? sv : mq_slb.pop_front();
        m_en   = 1'b1;
        m_src  = 1'b1;
        m_nick = sh.nick;
        m_dt   = sh.dt;
        m_ac   = 1'b0;
        m_jpc  = '0;
        m_last = 1'b1;
      end else begin
        m_en = 1'b0;
      end

      if (xe && !x_full && !(win == 0 && x_byp)) mq_ex.push_back(xv);
      if (se && !s_full && !(win == 1 && s_byp)) mq_slb.push_back(sv);
    end
  endtask

  // Drive one cycle at the negedge, advance the model, then compare after the next posedge
  task automatic step(input bit r, input bit rd, input bit clr,
                      input bit xe, input ex_ent_t xv, input bit se, input slb_ent_t sv);
    rst           = r;
    rdy           = rd;
    iclr          = clr;
    bus.iEX_en    = xe;
    bus.iEX_nick  = xv.nick;
    bus.iEX_dt    = xv.dt;
    bus.iEX_ac    = xv.ac;
    bus.iEX_j_pc  = xv.j_pc;
    bus.iSLB_en   = se;
    bus.iSLB_nick = sv.nick;
    bus.iSLB_dt   = sv.dt;
    model_edge(r, rd, clr, xe, xv, se, sv);
    @(negedge clk);
    check_val("cdb_en", 64'(bus.oCDB_en), 64'(m_en));
    check_val("cdb_src", 64'(bus.oCDB_src), 64'(m_src));
    check_val("cdb_nick", 64'(bus.oCDB_nick), 64'(m_nick));
    check_val("cdb_dt", 64'(bus.oCDB_dt), 64'(m_dt));
    check_val("cdb_ac", 64'(bus.oCDB_ac), 64'(m_ac));
    check_val("cdb_j_pc", 64'(bus.oCDB_j_pc), 64'(m_jpc));
    check_val("ex_stall", 64'(bus.oEX_stall), 64'(mq_ex.size() == Depth));
    check_val("slb_stall", 64'(bus.oSLB_stall), 64'(mq_slb.size() == Depth));
  endtask

  task automatic idle(input bit rd);
    step(1'b0, rd, 1'b0, 1'b0, ex_none, 1'b0, slb_none);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, ex_none, 1'b0, slb_none);
    step(1'b1, 1'b1, 1'b0, 1'b0, ex_none, 1'b0, slb_none);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; iclr = 1'b0;
    bus.iEX_en = 1'b0; bus.iEX_nick = '0; bus.iEX_dt = '0; bus.iEX_ac = 1'b0;
    bus.iEX_j_pc = '0; bus.iSLB_en = 1'b0; bus.iSLB_nick = '0; bus.iSLB_dt = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check_val("rst_en", 64'(bus.oCDB_en), 64'd0);
    check_val("rst_nick", 64'(bus.oCDB_nick), 64'd0);
    check_val("rst_ex_stall", 64'(bus.oEX_stall), 64'd0);

`ifndef CDB_BYPASS_EN
    // Single EX result, latency 2
    step(1'b0, 1'b1, 1'b0, 1'b1, mk_ex(3, 32'h55, 1'b1, 32'h100), 1'b0, slb_none);
    check_val("t1_c1_en", 64'(bus.oCDB_en), 64'd0);
    idle(1'b1);
    check_val("t1_en", 64'(bus.oCDB_en), 64'd1);
    check_val("t1_src", 64'(bus.oCDB_src), 64'd0);
    check_val("t1_nick", 64'(bus.oCDB_nick), 64'd3);
    check_val("t1_dt", 64'(bus.oCDB_dt), 64'h55);
    check_val("t1_ac", 64'(bus.oCDB_ac), 64'd1);
    check_val("t1_j_pc", 64'(bus.oCDB_j_pc), 64'h100);
    idle(1'b1);
    check_val("t1_c3_en", 64'(bus.oCDB_en), 64'd0);

    // Simultaneous EX/SLB pairs alternate EX, SLB, EX, SLB
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, mk_ex(4, 40, 1'b0, 0), 1'b1, mk_slb(5, 50));
    idle(1'b1);
    check_val("t2_a_nick", 64'(bus.oCDB_nick), 64'd4);
    check_val("t2_a_src", 64'(bus.oCDB_src), 64'd0);
    idle(1'b1);
    check_val("t2_b_nick", 64'(bus.oCDB_nick), 64'd5);
    check_val("t2_b_src", 64'(bus.oCDB_src), 64'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, mk_ex(6, 60, 1'b1, 32'h200), 1'b1, mk_slb(8, 80));
    idle(1'b1);
    check_val("t2_c_nick", 64'(bus.oCDB_nick), 64'd6);
    idle(1'b1);
    check_val("t2_d_nick", 64'(bus.oCDB_nick), 64'd8);
    check_val("t2_d_ac", 64'(bus.oCDB_ac), 64'd0);

    // Freeze with one EX entry queued
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, mk_ex(11, 32'hBEEF, 1'b0, 32'h40), 1'b0, slb_none);
    repeat (3) idle(1'b0);
    check_val("t5_frozen_en", 64'(bus.oCDB_en), 64'd0);
    idle(1'b1);
    check_val("t5_en", 64'(bus.oCDB_en), 64'd1);
    check_val("t5_nick", 64'(bus.oCDB_nick), 64'd11);
`else
    // Bypass: SLB result on empty FIFOs broadcast next cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, ex_none, 1'b1, mk_slb(9, 32'hAB));
    check_val("t6_en", 64'(bus.oCDB_en), 64'd1);
    check_val("t6_src", 64'(bus.oCDB_src), 64'd1);
    check_val("t6_nick", 64'(bus.oCDB_nick), 64'd9);
    check_val("t6_dt", 64'(bus.oCDB_dt), 64'hAB);
    check_val("t6_ac", 64'(bus.oCDB_ac), 64'd0);
    check_val("t6_j_pc", 64'(bus.oCDB_j_pc), 64'd0);
`endif

    // Saturate both producers to reach the stall boundary, then flush
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, mq_ex.size() < Depth, rand_ex(),
           mq_slb.size() < Depth, rand_slb());
    end
    step(1'b0, 1'b1, 1'b1, mq_ex.size() < Depth, rand_ex(), mq_slb.size() < Depth, rand_slb());
    check_val("t4_clr_en", 64'(bus.oCDB_en), 64'd0);
    check_val("t4_clr_ex_stall", 64'(bus.oEX_stall), 64'd0);
    check_val("t4_clr_slb_stall", 64'(bus.oSLB_stall), 64'd0);
    repeat (3) idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, mk_ex(7, 32'h77, 1'b0, 32'h70), 1'b0, slb_none);
    idle(1'b1);
    check_val("t4_new_nick", 64'(bus.oCDB_nick), 64'd7);
    check_val("t4_new_en", 64'(bus.oCDB_en), 64'd1);

    // Randomized traffic in three load phases
    for (int i = 0; i < 3000; i++) begin
      int load;
      bit r, rd, clr, xe, se;
      load = (i < 1000) ? 30 : ((i < 2000) ? 70 : 95);
      r    = ($urandom_range(0, 299) == 0);
      rd   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 59) == 0);
      xe   = ($urandom_range(0, 99) < load) && (mq_ex.size() < Depth);
      se   = ($urandom_range(0, 99) < load) && (mq_slb.size() < Depth);
      step(r, rd, clr, xe, rand_ex(), se, rand_slb());
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
